// File: rtl/plru_array.sv
// Per-set tree-PLRU state with registered victim query and forwarding.
// Optional PLRU_LOCK_EN adds per-way lock steering for the victim walk.
module plru_array #(
  parameter  int NUM_WAYS = 4,
  parameter  int NUM_SETS = 8,
  localparam int WAY_W    = $clog2(NUM_WAYS),
  localparam int SET_W    = (NUM_SETS > 1) ? $clog2(NUM_SETS) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                upd_valid,
  input  logic [SET_W-1:0]    upd_set,
  input  logic [WAY_W-1:0]    upd_way,
  input  logic                qry_valid,
  input  logic [SET_W-1:0]    qry_set,
  input  logic [NUM_WAYS-1:0] qry_valid_mask,
`ifdef PLRU_LOCK_EN
  input  logic [NUM_WAYS-1:0] qry_lock_mask,
  output logic                victim_all_locked,
`endif
  output logic                victim_valid,
  output logic [WAY_W-1:0]    victim_way,
  output logic                victim_invalid
);

  typedef logic [NUM_WAYS-1:0] tw_t;
  typedef logic [WAY_W-1:0]    way_t;

  logic [NUM_WAYS-2:0] tree_q [NUM_SETS];

  // Trees are padded by one unused top bit so a WAY_W-wide node index fits.
  function automatic tw_t tree_upd(tw_t t, way_t way);
    tw_t  r;
    way_t node;
    r    = t;
    node = '0;
    for (int l = WAY_W - 1; l >= 0; l--) begin
      r[node] = ~way[l];
      node    = node + node + WAY_W'(1) + WAY_W'(way[l]);
    end
    return r;
  endfunction

  function automatic logic sub_locked(tw_t lk, int base, int l);
    logic r;
    r = 1'b1;
    for (int w = 0; w < NUM_WAYS; w++)
      if (((w >> l) == base) && !lk[w]) r = 1'b0;
    return r;
  endfunction

  function automatic way_t tree_walk(tw_t t, tw_t lk);
    way_t node;
    way_t v;
    logic b;
    logic steer;
    node  = '0;
    v     = '0;
    steer = ~&lk;
    for (int l = WAY_W - 1; l >= 0; l--) begin
      b = t[node];
      if (steer && sub_locked(lk, ((int'(v) >> (l + 1)) << 1) | int'(b), l))
        b = ~b;
      v[l] = b;
      node = node + node + WAY_W'(1) + WAY_W'(b);
    end
    return v;
  endfunction

  tw_t  lk;
  tw_t  upd_nt;
  tw_t  qry_t;
  way_t nxt_way;
  logic nxt_inv;

`ifdef PLRU_LOCK_EN
  assign lk = qry_lock_mask;
`else
  assign lk = '0;
`endif

  always_comb begin
    upd_nt  = tree_upd({1'b0, tree_q[upd_set]}, upd_way);
    qry_t   = {1'b0, tree_q[qry_set]};
    if (upd_valid && (upd_set == qry_set))
      qry_t = upd_nt;
    nxt_inv = 1'b0;
    nxt_way = tree_walk(qry_t, lk);
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (!qry_valid_mask[w] && !lk[w]) begin
        nxt_inv = 1'b1;
        nxt_way = WAY_W'(w);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int s = 0; s < NUM_SETS; s++)
        tree_q[s] <= '0;
      victim_valid   <= 1'b0;
      victim_way     <= '0;
      victim_invalid <= 1'b0;
`ifdef PLRU_LOCK_EN
      victim_all_locked <= 1'b0;
`endif
    end else begin
      if (upd_valid)
        tree_q[upd_set] <= upd_nt[NUM_WAYS-2:0];
      victim_valid <= qry_valid;
      if (qry_valid) begin
        victim_way     <= nxt_way;
        victim_invalid <= nxt_inv;
`ifdef PLRU_LOCK_EN
        victim_all_locked <= &lk;
`endif
      end
    end
  end

endmodule

// File: tb/tb_plru_array.sv
// Directed self-checking bench for plru_array.
// Default build: 4 ways; with PLRU_LOCK_EN: 16-way lock checks.
module tb_plru_array;

`ifdef PLRU_LOCK_EN
  localparam int NW = 16;
`else
  localparam int NW = 4;
`endif
  localparam int WW = $clog2(NW);
  localparam int SW = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          upd_valid;
  logic [SW-1:0] upd_set;
  logic [WW-1:0] upd_way;
  logic          qry_valid;
  logic [SW-1:0] qry_set;
  logic [NW-1:0] qry_valid_mask;
  logic          victim_valid;
  logic [WW-1:0] victim_way;
  logic          victim_invalid;
`ifdef PLRU_LOCK_EN
  logic [NW-1:0] qry_lock_mask;
  logic          victim_all_locked;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  plru_array #(.NUM_WAYS(NW), .NUM_SETS(8)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .upd_valid(upd_valid),
    .upd_set(upd_set),
    .upd_way(upd_way),
    .qry_valid(qry_valid),
    .qry_set(qry_set),
    .qry_valid_mask(qry_valid_mask),
`ifdef PLRU_LOCK_EN
    .qry_lock_mask(qry_lock_mask),
    .victim_all_locked(victim_all_locked),
`endif
    .victim_valid(victim_valid),
    .victim_way(victim_way),
    .victim_invalid(victim_invalid)
  );

  task automatic step();
    @(posedge clk);
    #1;
    upd_valid = 1'b0;
    qry_valid = 1'b0;
  endtask

  task automatic upd(input int s, input int w);
    upd_valid = 1'b1;
    upd_set   = SW'(s);
    upd_way   = WW'(w);
    step();
  endtask

  task automatic qry(input int s, input logic [NW-1:0] m);
    qry_valid      = 1'b1;
    qry_set        = SW'(s);
    qry_valid_mask = m;
    step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    step();
    checks++;
    if ({victim_valid, victim_way, victim_invalid} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got v=%0b w=%0d i=%0b want 0 0 0",
               victim_valid, victim_way, victim_invalid);
    end
    rst_n = 1'b1;
    step();
    qry(3, '1);
    checks++;
    if (victim_valid !== 1'b1 || victim_way !== 0 || victim_invalid !== 1'b0) begin
      errors++;
      $display("FAIL reset_query: got v=%0b w=%0d i=%0b want 1 0 0",
               victim_valid, victim_way, victim_invalid);
    end
    step();
    checks++;
    if (victim_valid !== 1'b0 || victim_way !== 0) begin
      errors++;
      $display("FAIL idle_hold: got v=%0b w=%0d want 0 0",
               victim_valid, victim_way);
    end
  endtask

`ifndef PLRU_LOCK_EN
  task automatic test_update_seq();
    int ways [3] = '{0, 2, 1};
    int exp  [3] = '{2, 1, 3};
    for (int i = 0; i < 3; i++) begin
      upd(3, ways[i]);
      qry(3, '1);
      checks++;
      if (victim_valid !== 1'b1 || victim_way !== WW'(exp[i])) begin
        errors++;
        $display("FAIL update_seq%0d: got v=%0b w=%0d want 1 %0d",
                 i, victim_valid, victim_way, exp[i]);
      end
    end
    step();
    checks++;
    if (victim_valid !== 1'b0 || victim_way !== 2'd3) begin
      errors++;
      $display("FAIL hold_after_seq: got v=%0b w=%0d want 0 3",
               victim_valid, victim_way);
    end
  endtask

  task automatic test_invalid();
    logic [3:0] m [3] = '{4'b1011, 4'b0000, 4'b0111};
    int exp [3] = '{2, 0, 3};
    upd(5, 1);
    for (int i = 0; i < 3; i++) begin
      qry(5, m[i]);
      checks++;
      if (victim_way !== WW'(exp[i]) || victim_invalid !== 1'b1) begin
        errors++;
        $display("FAIL invalid%0d: got w=%0d i=%0b want %0d 1",
                 i, victim_way, victim_invalid, exp[i]);
      end
    end
    qry(5, '1);
    checks++;
    if (victim_way !== 2'd2 || victim_invalid !== 1'b0) begin
      errors++;
      $display("FAIL invalid_clear: got w=%0d i=%0b want 2 0",
               victim_way, victim_invalid);
    end
  endtask

  task automatic test_forward();
    upd_valid = 1'b1; upd_set = 3'd0; upd_way = 2'd0;
    qry(1, '1);
    checks++;
    if (victim_valid !== 1'b1 || victim_way !== 2'd0) begin
      errors++;
      $display("FAIL fwd_cross_set: got v=%0b w=%0d want 1 0",
               victim_valid, victim_way);
    end
    upd_valid = 1'b1; upd_set = 3'd1; upd_way = 2'd0;
    qry(1, '1);
    checks++;
    if (victim_valid !== 1'b1 || victim_way !== 2'd2) begin
      errors++;
      $display("FAIL fwd_same_set: got v=%0b w=%0d want 1 2",
               victim_valid, victim_way);
    end
    qry(1, '1);
    checks++;
    if (victim_way !== 2'd2) begin
      errors++;
      $display("FAIL fwd_persist: got w=%0d want 2", victim_way);
    end
  endtask

  task automatic test_back_to_back();
    int exp [3] = '{2, 0, 2};
    upd(6, 0);
    qry_valid = 1'b1; qry_set = 3'd6; qry_valid_mask = '1;
    @(posedge clk); #1;
    qry_set = 3'd7;
    checks++;
    if (victim_valid !== 1'b1 || victim_way !== WW'(exp[0])) begin
      errors++;
      $display("FAIL b2b0: got v=%0b w=%0d want 1 2", victim_valid, victim_way);
    end
    @(posedge clk); #1;
    qry_set = 3'd6;
    checks++;
    if (victim_valid !== 1'b1 || victim_way !== WW'(exp[1])) begin
      errors++;
      $display("FAIL b2b1: got v=%0b w=%0d want 1 0", victim_valid, victim_way);
    end
    step();
    checks++;
    if (victim_valid !== 1'b1 || victim_way !== WW'(exp[2])) begin
      errors++;
      $display("FAIL b2b2: got v=%0b w=%0d want 1 2", victim_valid, victim_way);
    end
  endtask

  task automatic test_reset_midrun();
    for (int s = 0; s < 8; s++) upd(s, 0);
    rst_n = 1'b0;
    qry_valid = 1'b1; qry_set = 3'd2; qry_valid_mask = '1;
    step();
    rst_n = 1'b1;
    checks++;
    if (victim_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_qry_dropped: got v=%0b want 0", victim_valid);
    end
    for (int s = 0; s < 8; s++) begin
      qry(s, '1);
      checks++;
      if (victim_valid !== 1'b1 || victim_way !== 2'd0) begin
        errors++;
        $display("FAIL post_reset_set%0d: got v=%0b w=%0d want 1 0",
                 s, victim_valid, victim_way);
      end
    end
  endtask
`else
  task automatic test_lock();
    qry_lock_mask = 16'h00FF;
    qry(2, '1);
    checks++;
    if (victim_way !== 4'd8 || victim_all_locked !== 1'b0) begin
      errors++;
      $display("FAIL lock_half: got w=%0d al=%0b want 8 0",
               victim_way, victim_all_locked);
    end
    qry_lock_mask = 16'hFFFF;
    qry(2, '1);
    checks++;
    if (victim_way !== 4'd0 || victim_all_locked !== 1'b1) begin
      errors++;
      $display("FAIL lock_all: got w=%0d al=%0b want 0 1",
               victim_way, victim_all_locked);
    end
    qry_lock_mask = 16'h0001;
    qry(2, 16'hFFF0);
    checks++;
    if (victim_way !== 4'd1 || victim_invalid !== 1'b1) begin
      errors++;
      $display("FAIL lock_invalid: got w=%0d i=%0b want 1 1",
               victim_way, victim_invalid);
    end
    qry_lock_mask = 16'h00F0;
    upd(2, 8);
    qry(2, '1);
    checks++;
    if (victim_way !== 4'd0 || victim_all_locked !== 1'b0) begin
      errors++;
      $display("FAIL lock_none_hit: got w=%0d al=%0b want 0 0",
               victim_way, victim_all_locked);
    end
    qry_lock_mask = 16'h000F;
    qry(2, '1);
    checks++;
    if (victim_way !== 4'd4) begin
      errors++;
      $display("FAIL lock_sibling: got w=%0d want 4", victim_way);
    end
  endtask
`endif

  initial begin
    rst_n = 1'b0;
    upd_valid = 1'b0; upd_set = '0; upd_way = '0;
    qry_valid = 1'b0; qry_set = '0; qry_valid_mask = '1;
`ifdef PLRU_LOCK_EN
    qry_lock_mask = '0;
`endif
    #1;
    test_reset();
`ifndef PLRU_LOCK_EN
    test_update_seq();
    test_invalid();
    test_forward();
    test_back_to_back();
    test_reset_midrun();
`else
    test_lock();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
